conv_kxk_acc: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 16-channel 5x5 convolution block.
- Takes one channel's KxK window and KxK filter per beat over a valid/ready handshake, forms the KxK dot product through a pipelined multiplier/adder tree, and accumulates N_CH beats.
- Adds one bias per group and emits a single conv value with an output handshake.
- Optional saturation on the output. Used by the C3/C5 layer sequencer in place of fully parallel channel instances.

---
 rtl/conv_kxk_acc.sv | 157 +++++++++++++++
 tb/tb_conv_kxk_acc.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_acc.sv
// Time-multiplexed KxK convolution. Each beat carries one channel's window and filter; a
// multiply / adder-tree / accumulate pipeline sums N_CH beats plus one bias per result.

module conv_kxk_acc #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int K         = 5,
  parameter int N_CH      = 16,
  parameter int SAT       = 0,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIT_WIDTH*K*K-1:0]   in_window,
  input  logic [BIT_WIDTH*K*K-1:0]   in_filter,
  input  logic [BIT_WIDTH-1:0]       bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_WIDTH-1:0]       conv_value,
  output logic [CH_W-1:0]            ch_idx
);

  localparam int KK    = K * K;
  localparam int PW    = 2 * BIT_WIDTH;
  localparam int ACC_W = PW + $clog2(KK * N_CH) + 1;
  localparam int LVLS  = $clog2(KK);
  localparam int NP    = 1 << LVLS;
  localparam int XW    = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic [XW-1:0] MAX_U = {XW{1'b1}} >> (XW - OUT_WIDTH + 1);

  logic adv, fire;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !clear && !rst;
  assign fire     = in_valid && in_ready;

  // S1: element-wise products
  logic signed [PW-1:0]    prod_d [KK];
  logic signed [PW-1:0]    prod_q [KK];
  logic                    s1_valid, s1_first, s1_last;
  logic signed [ACC_W-1:0] s1_bias;

  always_comb begin
    for (int i = 0; i < KK; i++) begin
      prod_d[i] = PW'($signed(in_window[BIT_WIDTH*i +: BIT_WIDTH]))
                * PW'($signed(in_filter[BIT_WIDTH*i +: BIT_WIDTH]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bias  <= '0;
      ch_idx   <= '0;
      for (int i = 0; i < KK; i++) prod_q[i] <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      ch_idx   <= '0;
    end else if (adv) begin
      s1_valid <= fire;
      if (fire) begin
        for (int i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
        s1_first <= (ch_idx == '0);
        s1_last  <= (ch_idx == CH_W'(N_CH - 1));
        s1_bias  <= ACC_W'($signed(bias));
        ch_idx   <= (ch_idx == CH_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
      end
    end
  end

  // Balanced adder tree, padded with zero leaves up to a power of two
  for (genvar lv = 0; lv <= LVLS; lv++) begin : g_lvl
    logic signed [ACC_W-1:0] node [NP >> lv];
    if (lv == 0) begin : g_leaf
      for (genvar j = 0; j < NP; j++) begin : g_j
        if (j < KK) begin : g_p
          assign node[j] = ACC_W'(prod_q[j]);
        end else begin : g_z
          assign node[j] = '0;
        end
      end
    end else begin : g_add
      for (genvar j = 0; j < (NP >> lv); j++) begin : g_j
        assign node[j] = g_lvl[lv-1].node[2*j] + g_lvl[lv-1].node[2*j+1];
      end
    end
  end

  logic signed [ACC_W-1:0] tree_sum;
  assign tree_sum = g_lvl[LVLS].node[0];

  // S2: registered beat sum
  logic                    s2_valid, s2_first, s2_last;
  logic signed [ACC_W-1:0] s2_bias, sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_bias  <= '0;
      sum_q    <= '0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_bias  <= s1_bias;
        sum_q    <= tree_sum;
      end
    end
  end

  // S3: first beat re-seeds with bias, later beats add onto acc
  logic signed [ACC_W-1:0]     acc_q, s3_val;
  logic signed [XW-1:0]        wide, sat_max, sat_min;
  logic        [OUT_WIDTH-1:0] out_d;

  always_comb begin
    s3_val  = (s2_first ? s2_bias : acc_q) + sum_q;
    wide    = XW'(s3_val);
    sat_max = $signed(MAX_U);
    sat_min = ~sat_max;
    out_d   = wide[OUT_WIDTH-1:0];
    if (SAT != 0) begin
      if (wide > sat_max)      out_d = sat_max[OUT_WIDTH-1:0];
      else if (wide < sat_min) out_d = sat_min[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      out_valid  <= 1'b0;
      conv_value <= '0;
    end else if (clear) begin
      acc_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (adv && s2_valid) begin
        acc_q <= s3_val;
        if (s2_last) begin
          out_valid  <= 1'b1;
          conv_value <= out_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_kxk_acc.sv
// Self-checking bench for conv_kxk_acc: default, 16-bit saturating/wrapping and K=3/N_CH=1
// instances, vector table, handshake corner cases and randomized groups vs a plain-arithmetic model.

module tb_conv_kxk_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [199:0] in_window = '0, in_filter = '0;
  logic [7:0]   bias = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [31:0]  conv_value;
  logic [3:0]   ch_idx;

  logic         s_valid = 1'b0;
  logic [199:0] s_win = '0, s_flt = '0;
  logic         s_ir_a, s_ov_a, s_ir_b, s_ov_b;
  logic [15:0]  s_cv_a, s_cv_b;
  logic [3:0]   s_ch_a, s_ch_b;

  logic         k_valid = 1'b0;
  logic [71:0]  k_win = '0, k_flt = '0;
  logic [7:0]   k_bias = '0;
  logic         k_ir, k_ov;
  logic [31:0]  k_cv;
  logic [0:0]   k_ch;

  conv_kxk_acc dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_window(in_window), .in_filter(in_filter), .bias(bias), .out_valid(out_valid),
    .out_ready(out_ready), .conv_value(conv_value), .ch_idx(ch_idx)
  );

  conv_kxk_acc #(.OUT_WIDTH(16), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(s_valid), .in_ready(s_ir_a),
    .in_window(s_win), .in_filter(s_flt), .bias(8'd0), .out_valid(s_ov_a),
    .out_ready(1'b1), .conv_value(s_cv_a), .ch_idx(s_ch_a)
  );

  conv_kxk_acc #(.OUT_WIDTH(16), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(s_valid), .in_ready(s_ir_b),
    .in_window(s_win), .in_filter(s_flt), .bias(8'd0), .out_valid(s_ov_b),
    .out_ready(1'b1), .conv_value(s_cv_b), .ch_idx(s_ch_b)
  );

  conv_kxk_acc #(.K(3), .N_CH(1)) dut_k3 (
    .clk(clk), .rst(rst), .clear(1'b0), .in_valid(k_valid), .in_ready(k_ir),
    .in_window(k_win), .in_filter(k_flt), .bias(k_bias), .out_valid(k_ov),
    .out_ready(1'b1), .conv_value(k_cv), .ch_idx(k_ch)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, want);
    end
  endtask

  function automatic logic [199:0] fill_main(input int v);
    logic [199:0] r;
    for (int e = 0; e < 25; e++) r[8*e +: 8] = 8'(v);
    return r;
  endfunction

  function automatic longint k3_model(input logic [71:0] w, input logic [71:0] f,
                                      input logic [7:0] b);
    longint s = longint'($signed(b));
    for (int e = 0; e < 9; e++) s += longint'($signed(w[8*e +: 8])) * longint'($signed(f[8*e +: 8]));
    return s;
  endfunction

  // out_ready: 0 = always ready, 1 = never ready, 2 = random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Main scoreboard: every output handshake pops one expected result; held output must not move
  longint      exp_q[$];
  logic        prev_hold = 1'b0, prev_clear = 1'b0;
  logic [31:0] prev_cv = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold && !prev_clear) begin
        check("hold_valid", out_valid, 1);
        check("hold_value", $signed(conv_value), $signed(prev_cv));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %0d, required no result", $signed(conv_value));
        end else begin
          check("result", $signed(conv_value), exp_q.pop_front());
        end
      end
      prev_hold  = out_valid && !out_ready;
      prev_clear = clear;
      prev_cv    = conv_value;
    end else begin
      prev_hold = 1'b0;
    end
  end

  longint kq[$];
  int     k_cnt = 0, k_first = 0, k_last = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (k_ov) begin
        if (kq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL k3_unexpected: got %0d, required no result", $signed(k_cv));
        end else begin
          check("k3_result", $signed(k_cv), kq.pop_front());
        end
        if (k_cnt == 0) k_first = cyc;
        k_last = cyc;
        k_cnt++;
      end
      if (k_valid && k_ir) kq.push_back(k3_model(k_win, k_flt, k_bias));
    end
  end

  task automatic send_beat(input logic [199:0] w, input logic [199:0] f, input logic [7:0] b);
    int n = 0;
    bit got = 0;
    in_valid  = 1'b1;
    in_window = w;
    in_filter = f;
    bias      = b;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept: in_ready low for %0d cycles, required 1", n);
    end
  endtask

  // Only the first beat's bias counts; later beats carry junk bias on purpose
  task automatic send_group(input int w, input int f, input int b, input longint want);
    exp_q.push_back(want);
    for (int i = 0; i < 16; i++) send_beat(fill_main(w), fill_main(f), (i == 0) ? 8'(b) : 8'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, out_valid, 1);
  endtask

  typedef struct {
    int     w;
    int     f;
    int     b;
    longint want;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 1, 0, 400};
    tbl[1] = '{1, 1, -3, 397};
    tbl[2] = '{1, 1, 5, 405};
    tbl[3] = '{-1, 1, 0, -400};
    tbl[4] = '{127, 127, -128, 6451472};
    tbl[5] = '{-128, -128, 127, 6553727};
    tbl[6] = '{-128, 127, 0, -6502400};
    tbl[7] = '{0, 5, -1, -1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_conv", conv_value, 0);
    check("rst_ch_idx", ch_idx, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency and ch_idx wrap with a default group of ones
    for (int i = 0; i < 15; i++) send_beat(fill_main(1), fill_main(1), (i == 0) ? 8'd0 : 8'($urandom));
    check("ch_idx_15", ch_idx, 15);
    exp_q.push_back(400);
    send_beat(fill_main(1), fill_main(1), 8'($urandom));
    in_valid = 1'b0;
    @(negedge clk);
    check("ch_idx_wrap", ch_idx, 0);
    check("lat_c1", out_valid, 0);
    @(negedge clk);
    check("lat_c2", out_valid, 0);
    @(negedge clk);
    check("lat_c3", out_valid, 1);
    check("lat_value", $signed(conv_value), 400);
    @(negedge clk);
    check("lat_c4", out_valid, 0);
    @(posedge clk);
    #1;

    // Vector table, back-to-back groups under random out_ready
    rdy_mode = 2;
    for (int t = 0; t < 8; t++) send_group(tbl[t].w, tbl[t].f, tbl[t].b, tbl[t].want);
    in_valid = 1'b0;
    drain();
    rdy_mode = 0;

    // Output stall: result held, no beat accepted, then next group completes
    rdy_mode = 1;
    send_group(1, 1, 0, 400);
    in_valid = 1'b0;
    wait_out("stall_result");
    in_valid  = 1'b1;
    in_window = fill_main(1);
    in_filter = fill_main(1);
    bias      = 8'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_value", $signed(conv_value), 400);
      check("stall_in_ready", in_ready, 0);
      check("stall_ch_idx", ch_idx, 0);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_group(1, 1, 0, 400);
    in_valid = 1'b0;
    drain();

    // clear discards a pending result
    rdy_mode = 1;
    send_beat(fill_main(2), fill_main(2), 8'd0);
    for (int i = 1; i < 16; i++) send_beat(fill_main(2), fill_main(2), 8'd0);
    in_valid = 1'b0;
    wait_out("pend_result");
    @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clr_discard", out_valid, 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // clear mid-group, then a fresh group
    for (int i = 0; i < 7; i++) send_beat(fill_main(1), fill_main(1), 8'd9);
    clear = 1'b1;
    @(negedge clk);
    check("clr_mid_in_ready", in_ready, 0);
    @(posedge clk);
    #1 clear = 1'b0;
    check("clr_mid_ch_idx", ch_idx, 0);
    send_group(1, 1, 0, 400);
    in_valid = 1'b0;
    drain();

    // rst mid-group, then a fresh group
    for (int i = 0; i < 7; i++) send_beat(fill_main(1), fill_main(1), 8'd9);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_conv", conv_value, 0);
    check("rst_mid_ch_idx", ch_idx, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rel", in_ready, 1);
    @(posedge clk);
    #1;
    send_group(1, 1, 0, 400);
    in_valid = 1'b0;
    drain();

    // Randomized groups with input gaps and random back-pressure
    rdy_mode = 2;
    for (int g = 0; g < 20; g++) begin
      logic [199:0] wv[16];
      logic [199:0] fv[16];
      logic [7:0]   bv;
      longint       want;
      bv   = 8'($urandom);
      want = longint'($signed(bv));
      for (int b = 0; b < 16; b++) begin
        for (int e = 0; e < 25; e++) begin
          wv[b][8*e +: 8] = 8'($urandom);
          fv[b][8*e +: 8] = 8'($urandom);
          want += longint'($signed(wv[b][8*e +: 8])) * longint'($signed(fv[b][8*e +: 8]));
        end
      end
      exp_q.push_back(want);
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
        send_beat(wv[b], fv[b], (b == 0) ? bv : 8'($urandom));
      end
    end
    in_valid = 1'b0;
    drain();
    rdy_mode = 0;

    // 16-bit output: saturating vs wrapping instances
    check("sat_in_ready", s_ir_a, 1);
    for (int grp = 0; grp < 2; grp++) begin
      int n;
      s_win   = fill_main((grp == 0) ? 127 : -128);
      s_flt   = fill_main(127);
      s_valid = 1'b1;
      repeat (16) begin
        @(posedge clk);
        #1;
      end
      s_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_ov_a && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("sat_valid", s_ov_a, 1);
      check("wrap_valid", s_ov_b, 1);
      check("sat_value", $signed(s_cv_a), (grp == 0) ? 32767 : -32768);
      check("wrap_value", $signed(s_cv_b), (grp == 0) ? 29072 : -14336);
      check("sat_ch_idx", s_ch_a + s_ch_b, 0);
      check("wrap_in_ready", s_ir_b, 1);
      @(posedge clk);
      #1;
    end

    // K=3, N_CH=1: one result per cycle under continuous in_valid
    for (int e = 0; e < 9; e++) begin
      k_win[8*e +: 8] = 8'(e + 1);
      k_flt[8*e +: 8] = 8'd2;
    end
    check("k3_first_model", k3_model(k_win, k_flt, 8'd1), 91);
    for (int i = 0; i < 8; i++) begin
      k_valid = 1'b1;
      k_bias  = 8'(3 * i + 1);
      k_win[7:0] = 8'(1 + i);
      @(posedge clk);
      #1;
    end
    k_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("k3_count", k_cnt, 8);
    check("k3_span", k_last - k_first, 7);
    check("k3_pending", kq.size(), 0);
    check("k3_ch_idx", k_ch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
